// File: rtl/cam_capture_ctrl_if.sv
// rtl/cam_capture_ctrl_if.sv - camera byte stream and frame-buffer write port
interface cam_capture_ctrl_if #(
   parameter int AW = 15,
   parameter int DW = 8
);
   logic          vsync;
   logic          href;
   logic [7:0]    px_data;
   logic [AW-1:0] addr_in;
   logic [DW-1:0] data_in;
   logic          regwrite;

   modport master (
      input  vsync, href, px_data,
      output addr_in, data_in, regwrite
   );

   modport slave (
      output vsync, href, px_data,
      input  addr_in, data_in, regwrite
   );
endinterface

// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - OV7670 RGB565 capture into an RGB332 frame buffer
module cam_capture_ctrl #(
   parameter int AW = 15,
   parameter int DW = 8,
   parameter int H  = 160,
   parameter int V  = 120
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                cont,
   input  logic                stop,
   cam_capture_ctrl_if.master  bus,
   output logic                busy,
   output logic                frame_done,
   output logic                err
);
   localparam int CW = $clog2(H + 1);
   localparam int RW = $clog2(V + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_VS = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            vs_q, vs_d;
   logic            hr_q, hr_d;
   logic            mode_q, mode_d;
   logic            stop_pend_q, stop_pend_d;
   logic            phase_q, phase_d;
   logic [5:0]      b1_q, b1_d;
   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic [AW-1:0]   row_base_q, row_base_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_q, data_d;
   logic            regwrite_q, regwrite_d;
   logic            busy_q, busy_d;
   logic            frame_done_q, frame_done_d;
   logic            err_q, err_d;

   logic vs_fall, vs_rise, hr_fall;

   assign vs_fall = vs_q & ~bus.vsync;
   assign vs_rise = ~vs_q & bus.vsync;
   assign hr_fall = hr_q & ~bus.href;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         vs_q         <= 1'b0;
         hr_q         <= 1'b0;
         mode_q       <= 1'b0;
         stop_pend_q  <= 1'b0;
         phase_q      <= 1'b0;
         b1_q         <= '0;
         col_q        <= '0;
         row_q        <= '0;
         row_base_q   <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         regwrite_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         vs_q         <= vs_d;
         hr_q         <= hr_d;
         mode_q       <= mode_d;
         stop_pend_q  <= stop_pend_d;
         phase_q      <= phase_d;
         b1_q         <= b1_d;
         col_q        <= col_d;
         row_q        <= row_d;
         row_base_q   <= row_base_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         regwrite_q   <= regwrite_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   // A stop arriving in the same cycle as the frame end still ends continuous mode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_WAIT_VS;
         end
         S_WAIT_VS: begin
            if (vs_fall) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (vs_rise) begin
               if (mode_q && !(stop_pend_q || stop)) state_d = S_WAIT_VS;
               else                                   state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      vs_d         = bus.vsync;
      hr_d         = bus.href;
      mode_d       = mode_q;
      stop_pend_d  = stop_pend_q;
      phase_d      = phase_q;
      b1_d         = b1_q;
      col_d        = col_q;
      row_d        = row_q;
      row_base_d   = row_base_q;
      addr_d       = addr_q;
      data_d       = data_q;
      regwrite_d   = 1'b0;
      frame_done_d = 1'b0;
      err_d        = err_q;

      if (state_q != S_IDLE && stop) stop_pend_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d = cont;
               err_d  = 1'b0;
            end
         end
         S_WAIT_VS: begin
            if (vs_fall) begin
               row_d      = '0;
               col_d      = '0;
               row_base_d = '0;
               phase_d    = 1'b0;
            end
         end
         S_CAPTURE: begin
            if (bus.href) begin
               if (!phase_q) begin
                  b1_d    = {bus.px_data[7:5], bus.px_data[2:0]};
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if (col_q < CW'(H) && row_q < RW'(V)) begin
                     data_d     = DW'({b1_q, bus.px_data[4:3]});
                     addr_d     = row_base_q + AW'(col_q);
                     regwrite_d = 1'b1;
                     col_d      = col_q + CW'(1);
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            if (hr_fall) begin
               if (col_q != CW'(H) || phase_q) err_d = 1'b1;
               if (row_q < RW'(V)) begin
                  row_d      = row_q + RW'(1);
                  row_base_d = row_base_q + AW'(H);
               end
               col_d   = '0;
               phase_d = 1'b0;
            end
            // row_d already includes a line that ends in this same cycle.
            if (vs_rise) begin
               if (row_d != RW'(V)) err_d = 1'b1;
               frame_done_d = 1'b1;
            end
         end
         default: ;
      endcase

      if (state_d == S_IDLE) stop_pend_d = 1'b0;
      busy_d = (state_d != S_IDLE);
   end

   assign bus.addr_in  = addr_q;
   assign bus.data_in  = data_q;
   assign bus.regwrite = regwrite_q;
   assign busy         = busy_q;
   assign frame_done   = frame_done_q;
   assign err          = err_q;
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb/tb_cam_capture_ctrl.sv - directed self-checking bench for cam_capture_ctrl
module tb_cam_capture_ctrl;
   localparam int AW = 15;
   localparam int DW = 8;
   localparam int H  = 4;
   localparam int V  = 3;

   logic clk;
   logic rst_n;
   logic start, cont, stop;
   logic busy, frame_done, err;

   int checks   = 0;
   int failures = 0;
   int wr_count = 0;
   int base;

   cam_capture_ctrl_if #(.AW(AW), .DW(DW)) bus ();

   cam_capture_ctrl #(.AW(AW), .DW(DW), .H(H), .V(V)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cont       (cont),
      .stop       (stop),
      .bus        (bus.master),
      .busy       (busy),
      .frame_done (frame_done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (bus.regwrite === 1'b1) wr_count++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start(input logic c);
      start = 1'b1;
      cont  = c;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      chk("err_cleared_by_start", err, 1'b0);
   endtask

   task automatic vs_pulse();
      bus.vsync = 1'b1;
      idle(3);
      bus.vsync = 1'b0;
      idle(3);
   endtask

   // Sends npix pixels on one line; cap says whether the block should be writing.
   task automatic send_line(input int npix, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] exp_data, input int row, input bit cap);
      for (int p = 0; p < npix; p++) begin
         bus.href    = 1'b1;
         bus.px_data = b1;
         @(negedge clk);
         chk("no_write_on_b1", bus.regwrite, 1'b0);
         bus.px_data = b2;
         @(negedge clk);
         if (cap && p < H && row < V) begin
            chk("regwrite", bus.regwrite, 1'b1);
            chk("addr_in", bus.addr_in, row * H + p);
            chk("data_in", bus.data_in, exp_data);
         end else begin
            chk("regwrite_dropped", bus.regwrite, 1'b0);
         end
      end
      bus.href    = 1'b0;
      bus.px_data = 8'h00;
      idle(3);
   endtask

   task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] exp_data, input bit cap);
      for (int r = 0; r < V; r++) send_line(H, b1, b2, exp_data, r, cap);
   endtask

   task automatic end_frame(input logic exp_fd, input logic exp_busy);
      bus.vsync = 1'b1;
      @(negedge clk);
      chk("frame_done_pulse", frame_done, exp_fd);
      chk("busy_at_frame_done", busy, exp_busy);
      @(negedge clk);
      chk("frame_done_one_cycle", frame_done, 1'b0);
      idle(2);
      bus.vsync = 1'b0;
      idle(3);
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      cont        = 1'b0;
      stop        = 1'b0;
      bus.vsync   = 1'b0;
      bus.href    = 1'b0;
      bus.px_data = 8'h00;
      idle(2);
      chk("rst_addr", bus.addr_in, 0);
      chk("rst_data", bus.data_in, 0);
      chk("rst_regwrite", bus.regwrite, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      idle(2);

      // Clean single frame: E7/18 packs to 111_111_11.
      base = wr_count;
      do_start(1'b0);
      vs_pulse();
      send_frame(8'hE7, 8'h18, 8'hFF, 1'b1);
      end_frame(1'b1, 1'b0);
      chk("clean_write_count", wr_count - base, 12);
      chk("clean_err", err, 1'b0);
      chk("clean_idle", busy, 1'b0);

      // Start mid-frame: A4/55 packs to 101_100_10.
      base = wr_count;
      vs_pulse();
      send_line(H, 8'hA4, 8'h55, 8'hB2, 0, 1'b0);
      do_start(1'b0);
      send_line(H, 8'hA4, 8'h55, 8'hB2, 1, 1'b0);
      send_line(H, 8'hA4, 8'h55, 8'hB2, 2, 1'b0);
      end_frame(1'b0, 1'b1);
      chk("midframe_no_writes", wr_count - base, 0);
      send_frame(8'hA4, 8'h55, 8'hB2, 1'b1);
      end_frame(1'b1, 1'b0);
      chk("midframe_write_count", wr_count - base, 12);
      chk("midframe_err", err, 1'b0);

      // Long line: fifth pixel of line 1 is dropped.
      base = wr_count;
      do_start(1'b0);
      vs_pulse();
      send_line(H, 8'h3A, 8'hC9, 8'h29, 0, 1'b1);
      chk("long_err_before", err, 1'b0);
      send_line(5, 8'h3A, 8'hC9, 8'h29, 1, 1'b1);
      chk("long_err", err, 1'b1);
      send_line(H, 8'h3A, 8'hC9, 8'h29, 2, 1'b1);
      end_frame(1'b1, 1'b0);
      chk("long_write_count", wr_count - base, 12);
      chk("long_err_sticky", err, 1'b1);

      // Short line: line 1 has three pixels; line 2 still starts at 8.
      base = wr_count;
      do_start(1'b0);
      vs_pulse();
      send_line(H, 8'hE7, 8'h18, 8'hFF, 0, 1'b1);
      send_line(3, 8'hE7, 8'h18, 8'hFF, 1, 1'b1);
      chk("short_err", err, 1'b1);
      send_line(H, 8'hE7, 8'h18, 8'hFF, 2, 1'b1);
      end_frame(1'b1, 1'b0);
      chk("short_write_count", wr_count - base, 11);

      // Continuous, two frames, stop during frame 2.
      base = wr_count;
      do_start(1'b1);
      vs_pulse();
      send_frame(8'h3A, 8'hC9, 8'h29, 1'b1);
      end_frame(1'b1, 1'b1);
      send_line(H, 8'hA4, 8'h55, 8'hB2, 0, 1'b1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("cont_busy_after_stop", busy, 1'b1);
      send_line(H, 8'hA4, 8'h55, 8'hB2, 1, 1'b1);
      send_line(H, 8'hA4, 8'h55, 8'hB2, 2, 1'b1);
      end_frame(1'b1, 1'b0);
      chk("cont_write_count", wr_count - base, 24);
      chk("cont_err", err, 1'b0);
      vs_pulse();
      chk("cont_stays_idle", busy, 1'b0);

      // Reset after five bytes of line 1.
      do_start(1'b0);
      vs_pulse();
      send_line(H, 8'hE7, 8'h18, 8'hFF, 0, 1'b1);
      for (int p = 0; p < 2; p++) begin
         bus.href    = 1'b1;
         bus.px_data = 8'hA4;
         @(negedge clk);
         bus.px_data = 8'h55;
         @(negedge clk);
      end
      bus.px_data = 8'hA4;
      @(negedge clk);
      chk("pre_reset_addr", bus.addr_in, 5);
      chk("pre_reset_busy", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_regwrite", bus.regwrite, 1'b0);
      chk("async_rst_addr", bus.addr_in, 0);
      chk("async_rst_data", bus.data_in, 0);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_frame_done", frame_done, 1'b0);
      chk("async_rst_err", err, 1'b0);
      bus.href    = 1'b0;
      bus.px_data = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      vs_pulse();
      chk("post_rst_idle", busy, 1'b0);
      base = wr_count;
      do_start(1'b0);
      vs_pulse();
      send_frame(8'hA4, 8'h55, 8'hB2, 1'b1);
      end_frame(1'b1, 1'b0);
      chk("post_rst_write_count", wr_count - base, 12);
      chk("post_rst_err", err, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
